// File: rtl/weight_train_ctrl.sv
// weight_train_ctrl: closed-loop memristor synapse weight training sequencer.
// Each iteration reads every channel through the ADC handshake, classifies the
// samples against the [WEIGHT_MIN, WEIGHT_MAX] window, reports them as a UART
// frame and requests one potentiate/depress pulse round. It stops when every
// channel is in window (done) or the WRITE-round budget is used up (fail).
module weight_train_ctrl #(
  parameter int         N_CH       = 4,
  parameter int         ADC_W      = 12,
  parameter int         WEIGHT_MIN = 768,
  parameter int         WEIGHT_MAX = 1024,
  parameter int         MAX_ITER   = 255,
  parameter int         ITER_W     = 8,
  parameter logic [7:0] HDR_BYTE   = 8'hAA,
  localparam int        CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    adc_req,
  output logic [CH_W-1:0]         adc_ch,
  input  logic                    adc_valid,
  input  logic [ADC_W-1:0]        adc_data,
  output logic                    pulse_req,
  output logic [2*N_CH-1:0]       pulse_mode,
  input  logic                    pulse_done,
  output logic                    uart_send,
  output logic [7:0]              uart_data,
  input  logic                    uart_done,
  output logic [N_CH*ADC_W-1:0]   weights,
  output logic [ITER_W-1:0]       iter_cnt,
  output logic                    done,
  output logic                    fail
);

  localparam int          NBYTES = 2 * N_CH + 2;
  localparam int          BI_W   = $clog2(NBYTES);
  localparam logic [31:0] WMIN_U = 32'(WEIGHT_MIN);
  localparam logic [31:0] WMAX_U = 32'(WEIGHT_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_COMPARE, S_REPORT, S_CHECK, S_WRITE, S_DONE, S_FAIL
  } state_t;

  state_t            state;
  logic [2*N_CH-1:0] cls_q;
  logic              all_ok_q;
  logic              fail_next_q;
  logic [BI_W-1:0]   byte_idx;
  logic [2*N_CH-1:0] cls_c;
  logic              all_ok_c;

  // Window classification: 1 = needs potentiation, 2 = needs depression, 0 = in window.
  function automatic logic [1:0] classify(input logic [ADC_W-1:0] w);
    logic [31:0] wz;
    wz = 32'(w);
    if (wz <= WMIN_U) return 2'd1;
    else if (wz >= WMAX_U) return 2'd2;
    else return 2'd0;
  endfunction

  // Iteration count saturates at the budget so it can never wrap.
  function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
    return (v == ITER_W'(MAX_ITER)) ? v : v + ITER_W'(1);
  endfunction

  // Report frame: header, then high/low byte per channel, then status byte.
  function automatic logic [7:0] frame_byte(input logic [BI_W-1:0]       idx,
                                            input logic [N_CH*ADC_W-1:0] wts,
                                            input logic                  ok,
                                            input logic                  fn);
    logic [15:0] wz;
    int          k;
    frame_byte = 8'h00;
    wz         = '0;
    k          = 0;
    if (idx == '0) begin
      frame_byte = HDR_BYTE;
    end else if (idx == BI_W'(NBYTES - 1)) begin
      frame_byte = {ok, fn, 6'b0};
    end else begin
      k          = int'(idx) - 1;
      wz         = 16'(wts[(k / 2) * ADC_W +: ADC_W]);
      frame_byte = (k[0] == 1'b0) ? wz[15:8] : wz[7:0];
    end
  endfunction

  // Per-channel class vector and all-in-window flag from the captured samples.
  always_comb begin
    cls_c    = '0;
    all_ok_c = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      cls_c[2*c +: 2] = classify(weights[c*ADC_W +: ADC_W]);
      if (cls_c[2*c +: 2] != 2'd0) all_ok_c = 1'b0;
    end
  end

  // Training sequencer; start low is a synchronous abort that clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      adc_req     <= 1'b0;
      adc_ch      <= '0;
      pulse_req   <= 1'b0;
      pulse_mode  <= '0;
      uart_send   <= 1'b0;
      uart_data   <= '0;
      weights     <= '0;
      iter_cnt    <= '0;
      done        <= 1'b0;
      fail        <= 1'b0;
      cls_q       <= '0;
      all_ok_q    <= 1'b0;
      fail_next_q <= 1'b0;
      byte_idx    <= '0;
    end else if (!start) begin
      state       <= S_IDLE;
      adc_req     <= 1'b0;
      adc_ch      <= '0;
      pulse_req   <= 1'b0;
      pulse_mode  <= '0;
      uart_send   <= 1'b0;
      uart_data   <= '0;
      weights     <= '0;
      iter_cnt    <= '0;
      done        <= 1'b0;
      fail        <= 1'b0;
      cls_q       <= '0;
      all_ok_q    <= 1'b0;
      fail_next_q <= 1'b0;
      byte_idx    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_READ;
          adc_ch   <= '0;
          iter_cnt <= '0;
          adc_req  <= 1'b1;
        end
        S_READ: begin
          if (adc_req) begin
            if (adc_valid) begin
              weights[adc_ch*ADC_W +: ADC_W] <= adc_data;
              adc_req <= 1'b0;
              if (adc_ch == CH_W'(N_CH - 1)) begin
                adc_ch <= '0;
                state  <= S_COMPARE;
              end
            end
          end else begin
            // One idle cycle after each capture, then request the next channel.
            adc_ch  <= adc_ch + CH_W'(1);
            adc_req <= 1'b1;
          end
        end
        S_COMPARE: begin
          cls_q       <= cls_c;
          all_ok_q    <= all_ok_c;
          fail_next_q <= !all_ok_c && (iter_cnt == ITER_W'(MAX_ITER));
          byte_idx    <= '0;
          uart_send   <= 1'b1;
          uart_data   <= HDR_BYTE;
          state       <= S_REPORT;
        end
        S_REPORT: begin
          uart_send <= 1'b0;
          if (!uart_send && uart_done) begin
            if (byte_idx == BI_W'(NBYTES - 1)) begin
              state <= S_CHECK;
            end else begin
              byte_idx  <= byte_idx + BI_W'(1);
              uart_send <= 1'b1;
              uart_data <= frame_byte(byte_idx + BI_W'(1), weights, all_ok_q, fail_next_q);
            end
          end
        end
        S_CHECK: begin
          if (all_ok_q) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (fail_next_q) begin
            fail  <= 1'b1;
            state <= S_FAIL;
          end else begin
            pulse_req  <= 1'b1;
            pulse_mode <= cls_q;
            state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (pulse_done) begin
            pulse_req  <= 1'b0;
            pulse_mode <= '0;
            iter_cnt   <= sat_inc(iter_cnt);
            adc_ch     <= '0;
            adc_req    <= 1'b1;
            state      <= S_READ;
          end
        end
        S_DONE, S_FAIL: begin
          state <= state;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_train_ctrl.sv
// Randomized scoreboard bench for weight_train_ctrl: a reference model queues
// expected ADC reads, frame bytes and pulse modes; responder/monitor processes
// emulate the ADC, UART and pulse layers and compare against the queues.
module tb_weight_train_ctrl;
  localparam int N_CH       = 4;
  localparam int ADC_W      = 12;
  localparam int WEIGHT_MIN = 768;
  localparam int WEIGHT_MAX = 1024;
  localparam int MAX_ITER   = 3;
  localparam int ITER_W     = 8;
  localparam int CH_W       = 2;
  localparam int RUN_BOUND  = 3000;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic                  adc_req;
  logic [CH_W-1:0]       adc_ch;
  logic                  adc_valid;
  logic [ADC_W-1:0]      adc_data;
  logic                  pulse_req;
  logic [2*N_CH-1:0]     pulse_mode;
  logic                  pulse_done;
  logic                  uart_send;
  logic [7:0]            uart_data;
  logic                  uart_done;
  logic [N_CH*ADC_W-1:0] weights;
  logic [ITER_W-1:0]     iter_cnt;
  logic                  done;
  logic                  fail;

  weight_train_ctrl #(
    .N_CH(N_CH), .ADC_W(ADC_W), .WEIGHT_MIN(WEIGHT_MIN), .WEIGHT_MAX(WEIGHT_MAX),
    .MAX_ITER(MAX_ITER), .ITER_W(ITER_W), .HDR_BYTE(8'hAA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .adc_req(adc_req), .adc_ch(adc_ch), .adc_valid(adc_valid), .adc_data(adc_data),
    .pulse_req(pulse_req), .pulse_mode(pulse_mode), .pulse_done(pulse_done),
    .uart_send(uart_send), .uart_data(uart_data), .uart_done(uart_done),
    .weights(weights), .iter_cnt(iter_cnt), .done(done), .fail(fail)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int data; bit first; } adc_item_t;
  typedef struct { int b; bit first; } byte_item_t;

  adc_item_t  adc_q[$];
  byte_item_t byte_q[$];
  int         pm_q[$];

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  int send_cnt = 0;
  int last_adc_cyc = 0;
  int last_udone_cyc = 0;
  int max_dly = 4;
  int adc_dly_fix = -1;
  int uart_dly_fix = -1;
  int pulse_dly_fix = -1;
  int exp_done, exp_fail, exp_iter;
  logic [N_CH*ADC_W-1:0] exp_w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int pick(input int fix);
    return (fix >= 0) ? fix : int'($urandom_range(0, max_dly));
  endfunction

  task automatic check_zero(input string tag);
    check({tag, " adc_req"},    64'(adc_req),    64'(0));
    check({tag, " adc_ch"},     64'(adc_ch),     64'(0));
    check({tag, " pulse_req"},  64'(pulse_req),  64'(0));
    check({tag, " pulse_mode"}, 64'(pulse_mode), 64'(0));
    check({tag, " uart_send"},  64'(uart_send),  64'(0));
    check({tag, " uart_data"},  64'(uart_data),  64'(0));
    check({tag, " weights"},    64'(weights),    64'(0));
    check({tag, " iter_cnt"},   64'(iter_cnt),   64'(0));
    check({tag, " done"},       64'(done),       64'(0));
    check({tag, " fail"},       64'(fail),       64'(0));
  endtask

  task automatic flush_queues();
    adc_q.delete();
    byte_q.delete();
    pm_q.delete();
  endtask

  // ADC emulation: serve queued samples after a delay, checking channel and hold.
  initial begin : adc_resp
    adc_item_t it;
    int        d;
    bit        ab, stable;
    adc_valid = 1'b0;
    adc_data  = '0;
    forever begin
      @(negedge clk);
      adc_valid = 1'b0;
      if (rst_n && start && adc_req) begin
        if (adc_q.size() == 0) begin
          check("adc_req unexpected", 64'(1), 64'(0));
          while (rst_n && start && adc_req) @(negedge clk);
        end else begin
          it = adc_q.pop_front();
          check("adc_ch", 64'(adc_ch), 64'(it.ch));
          if (!it.first) check("adc_req latency", 64'(cyc), 64'(last_adc_cyc + 2));
          d = pick(adc_dly_fix);
          ab = 1'b0;
          stable = 1'b1;
          for (int i = 0; i < d; i++) begin
            @(negedge clk);
            if (!rst_n || !start) begin ab = 1'b1; break; end
            if (!(adc_req === 1'b1 && int'(adc_ch) == it.ch)) stable = 1'b0;
          end
          if (!ab) begin
            if (d > 0) check("adc_req hold", 64'(stable), 64'(1));
            adc_valid    = 1'b1;
            adc_data     = it.data[ADC_W-1:0];
            last_adc_cyc = cyc;
            @(negedge clk);
            if (rst_n && start) check("adc_req drop", 64'(adc_req), 64'(0));
            // Stray strobe while no request is outstanding must be ignored.
            adc_valid = ($urandom_range(0, 1) == 1);
            adc_data  = ADC_W'($urandom);
          end
        end
      end
    end
  end

  // UART emulation: compare each sent byte, hold for a while, then acknowledge.
  initial begin : uart_resp
    byte_item_t it;
    int         d;
    bit         ab, stable;
    logic [7:0] held;
    uart_done = 1'b0;
    forever begin
      @(negedge clk);
      uart_done = 1'b0;
      if (rst_n && start && uart_send) begin
        send_cnt++;
        held = uart_data;
        if (byte_q.size() == 0) begin
          check("uart_send unexpected", 64'(1), 64'(0));
        end else begin
          it = byte_q.pop_front();
          check("uart_byte", 64'(uart_data), 64'(it.b));
          if (!it.first) check("uart_send latency", 64'(cyc), 64'(last_udone_cyc + 1));
        end
        d = 1 + pick(uart_dly_fix);
        ab = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          if (!rst_n || !start) begin ab = 1'b1; break; end
          if (!(uart_send === 1'b0 && uart_data === held)) stable = 1'b0;
        end
        if (!ab) begin
          check("uart_send pulse/hold", 64'(stable), 64'(1));
          uart_done      = 1'b1;
          last_udone_cyc = cyc;
        end
      end
    end
  end

  // Pulse layer emulation: compare the mode vector, hold, then finish the round.
  initial begin : pulse_resp
    int          exp, d;
    bit          ab, stable;
    logic [7:0]  held;
    pulse_done = 1'b0;
    forever begin
      @(negedge clk);
      pulse_done = 1'b0;
      if (rst_n && start && pulse_req) begin
        if (pm_q.size() == 0) begin
          check("pulse_req unexpected", 64'(1), 64'(0));
        end else begin
          exp = pm_q.pop_front();
          check("pulse_mode", 64'(pulse_mode), 64'(exp));
          check("pulse_req latency", 64'(cyc), 64'(last_udone_cyc + 2));
        end
        held = pulse_mode;
        d = pick(pulse_dly_fix);
        ab = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          if (!rst_n || !start) begin ab = 1'b1; break; end
          if (!(pulse_req === 1'b1 && pulse_mode === held)) stable = 1'b0;
        end
        if (!ab) begin
          if (d > 0) check("pulse hold", 64'(stable), 64'(1));
          pulse_done = 1'b1;
          @(negedge clk);
          pulse_done = 1'b0;
          if (rst_n && start) begin
            check("pulse_req drop", 64'(pulse_req), 64'(0));
            check("pulse_mode clear", 64'(pulse_mode), 64'(0));
          end
        end
      end
    end
  end

  // Reference model: plan samples per iteration and queue the expected traffic.
  // plan 0: all 900, 1: 700/1100/768/1024 then 900, 2: all 500,
  // 3: random, 4: always out of window.
  task automatic run_plan(input int plan);
    int        s[N_CH];
    int        t[N_CH] = '{700, 1100, 768, 1024};
    int        it, pm, cat;
    bit        ok, fn, allin;
    adc_item_t  ai;
    byte_item_t bi;
    it = 0;
    forever begin
      ok = 1'b1;
      pm = 0;
      allin = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < N_CH; c++) begin
        case (plan)
          0: s[c] = 900;
          1: s[c] = (it == 0) ? t[c] : 900;
          2: s[c] = 500;
          4: s[c] = (c % 2 == 0) ? 100 : 3000;
          default: begin
            cat = allin ? 7 : int'($urandom_range(0, 7));
            case (cat)
              0: s[c] = 767 + int'($urandom_range(0, 2));
              1: s[c] = 1022 + int'($urandom_range(0, 3));
              2: s[c] = int'($urandom_range(0, 767));
              3: s[c] = int'($urandom_range(1025, 4095));
              4: s[c] = 0;
              5: s[c] = 4095;
              default: s[c] = 769 + int'($urandom_range(0, 254));
            endcase
          end
        endcase
        ai.ch = c; ai.data = s[c]; ai.first = (c == 0);
        adc_q.push_back(ai);
        exp_w[c*ADC_W +: ADC_W] = s[c][ADC_W-1:0];
        if (s[c] <= WEIGHT_MIN) begin pm += 1 << (2 * c); ok = 1'b0; end
        else if (s[c] >= WEIGHT_MAX) begin pm += 2 << (2 * c); ok = 1'b0; end
      end
      fn = !ok && (it == MAX_ITER);
      bi.first = 1'b1; bi.b = 'hAA;
      byte_q.push_back(bi);
      bi.first = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        bi.b = s[c] / 256; byte_q.push_back(bi);
        bi.b = s[c] % 256; byte_q.push_back(bi);
      end
      bi.b = (ok ? 128 : 0) + (fn ? 64 : 0);
      byte_q.push_back(bi);
      if (ok) begin exp_done = 1; exp_fail = 0; exp_iter = it; break; end
      if (fn) begin exp_done = 0; exp_fail = 1; exp_iter = it; break; end
      pm_q.push_back(pm);
      it++;
    end
  endtask

  task automatic do_run(input int plan);
    int n;
    bit quiet;
    run_plan(plan);
    start = 1'b1;
    n = 0;
    while (!(done || fail) && n < RUN_BOUND) begin @(negedge clk); n++; end
    check("run finished", 64'(done || fail), 64'(1));
    check("done", 64'(done), 64'(exp_done));
    check("fail", 64'(fail), 64'(exp_fail));
    check("iter_cnt", 64'(iter_cnt), 64'(exp_iter));
    check("weights", 64'(weights), 64'(exp_w));
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (adc_req || pulse_req || uart_send) quiet = 1'b0;
      if (done !== 1'(exp_done) || fail !== 1'(exp_fail) || weights !== exp_w) quiet = 1'b0;
    end
    check("final state held quiet", 64'(quiet), 64'(1));
    check("queues drained", 64'(adc_q.size() + byte_q.size() + pm_q.size()), 64'(0));
    start = 1'b0;
    @(negedge clk);
    check_zero("start low");
    flush_queues();
    @(negedge clk);
  endtask

  initial begin : main
    int n, base;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("idle");

    do_run(0);
    do_run(1);
    do_run(2);
    adc_dly_fix = 50; uart_dly_fix = 20;
    do_run(1);
    adc_dly_fix = -1; uart_dly_fix = -1;

    // Abort in the middle of a report frame.
    run_plan(4);
    start = 1'b1;
    base = send_cnt;
    n = 0;
    while (send_cnt < base + 3 && n < RUN_BOUND) begin @(negedge clk); n++; end
    check("reached report", 64'(send_cnt >= base + 3), 64'(1));
    start = 1'b0;
    @(negedge clk);
    check_zero("abort report");
    flush_queues();
    @(negedge clk);
    do_run(1);

    // Abort during the second pulse round.
    pulse_dly_fix = 10;
    run_plan(4);
    start = 1'b1;
    n = 0;
    while (!(pulse_req && iter_cnt == 1) && n < RUN_BOUND) begin @(negedge clk); n++; end
    check("reached write iter 1", 64'(pulse_req && iter_cnt == 1), 64'(1));
    start = 1'b0;
    @(negedge clk);
    check_zero("abort write");
    flush_queues();
    pulse_dly_fix = -1;
    @(negedge clk);
    do_run(0);

    // Asynchronous reset while reading channel 2.
    adc_dly_fix = 10;
    run_plan(0);
    start = 1'b1;
    n = 0;
    while (!(adc_req && adc_ch == 2) && n < RUN_BOUND) begin @(negedge clk); n++; end
    check("reached read ch2", 64'(adc_req && adc_ch == 2), 64'(1));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero("async reset");
    @(negedge clk);
    start = 1'b0;
    flush_queues();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    adc_dly_fix = -1;

    for (int r = 0; r < 8; r++) do_run(3);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/weight_train_ctrl.md
Name: weight_train_ctrl

Overview:
- Parametrised closed-loop synapse-weight training controller for N_CH memristor channels.
- Each iteration runs READ, then COMPARE, then REPORT, then WRITE:
  - READ: reads each channel's averaged ADC value through a request/valid handshake.
  - COMPARE: classifies each value against a programmable window.
  - REPORT: sends a framed weight report over the UART transmitter.
  - WRITE: requests one potentiate/depress pulse round from the DAC/switch layer.
- Iterates until every channel is in-window (DONE) or an iteration budget expires (FAIL).
- Sits between the board top level and the adc_top/dac_top/uart_tx blocks; it is the successor to the fixed 4-channel training sequencer.

Parameters:
- N_CH, 4, number of synapse channels (1..16)
- ADC_W, 12, ADC sample width (9..16)
- WEIGHT_MIN, 768, lower window bound; sample <= WEIGHT_MIN needs potentiation
- WEIGHT_MAX, 1024, upper window bound; sample >= WEIGHT_MAX needs depression
- MAX_ITER, 255, maximum WRITE rounds before FAIL
- ITER_W, 8, iteration counter width (2^ITER_W > MAX_ITER)
- HDR_BYTE, 8'hAA, UART frame header

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, asynchronous active-low reset
- start, input, 1, level enable (debounced key); low aborts to IDLE
- adc_req, output, 1, ADC conversion request, held until adc_valid
- adc_ch, output, CH_W=max(1,clog2(N_CH)), channel being read
- adc_valid, input, 1, one-cycle strobe; adc_data valid
- adc_data, input, ADC_W, averaged sample
- pulse_req, output, 1, pulse-round request, held until pulse_done
- pulse_mode, output, 2*N_CH, per channel: 0 none, 1 potentiate, 2 depress
- pulse_done, input, 1, one-cycle strobe; pulse round finished
- uart_send, output, 1, one-cycle send strobe
- uart_data, output, 8, byte to transmit
- uart_done, input, 1, one-cycle strobe; byte finished
- weights, output, N_CH*ADC_W, last captured samples, ch0 in LSBs
- iter_cnt, output, ITER_W, completed WRITE rounds
- done, output, 1, all channels in window
- fail, output, 1, budget exhausted

Behaviour:
- Reset / abort values: all outputs 0, state IDLE.
  - Reset is asynchronous.
  - start low in any state: synchronous return to IDLE; all outputs and registers reach reset values on the next edge.
- FSM states: IDLE, READ, COMPARE, REPORT, CHECK, WRITE, DONE, FAIL.
- IDLE: start high moves to READ on the next edge, with ch=0 and iter_cnt=0.
- READ:
  - adc_req=1 with adc_ch=ch.
  - On adc_valid: weights[ch] <= adc_data; adc_req drops on the next cycle, then re-asserts with ch+1 on the cycle after.
  - After channel N_CH-1 is captured, go to COMPARE.
  - adc_valid outside READ, or while adc_req=0, is ignored.
- COMPARE (1 cycle): per channel, class = 1 if w<=WEIGHT_MIN, 2 if w>=WEIGHT_MAX, otherwise 0 (in window). Comparisons are unsigned. all_ok = all classes 0.
- REPORT: frame of 2*N_CH+2 bytes, in this order:
  - HDR_BYTE;
  - per channel: high byte = zero-extended w[ADC_W-1:8], then low byte = w[7:0];
  - status byte {all_ok, fail_next, 6'b0}, where fail_next = !all_ok && iter_cnt==MAX_ITER.
- UART handshake: uart_send pulses exactly 1 cycle with uart_data stable; the next byte is not sent until uart_done. uart_data holds until the next send.
- CHECK (1 cycle): all_ok → DONE; else fail_next → FAIL; else WRITE.
- WRITE:
  - pulse_mode = class vector, held stable for the whole state; pulse_req=1.
  - On pulse_done: pulse_req=0, iter_cnt++, ch=0, then READ.
  - pulse_mode returns to 0 on exit.
- DONE/FAIL: done or fail =1, held with weights and iter_cnt until start falls. No further requests are issued.
- Latency:
  - adc_valid to next adc_req: 2 cycles.
  - uart_done to next uart_send: 1 cycle.
  - Last uart_done to pulse_req: 2 cycles.
- Simultaneous start-fall with any strobe: the abort wins and the strobe is dropped.
- iter_cnt never wraps; FAIL is entered at MAX_ITER.

Test Plan:
- N_CH=4, samples 900,900,900,900 → one frame AA 03 84 03 84 03 84 03 84 80, then done=1, iter_cnt=0, pulse_req never asserted.
- Samples 700,1100,768,1024 → pulse_mode=8'b10_01_10_01 (ch0 in LSBs), i.e. ch0 and ch2 potentiate, ch1 and ch3 depress; status byte 00. Return 900 on all channels in the next READ → done=1, iter_cnt=1.
- All samples 500 every iteration, MAX_ITER=3 → 3 WRITE rounds; last status byte 40; fail=1, iter_cnt=3.
- Delay adc_valid by 50 cycles and uart_done by 20 cycles → adc_req/uart_data held stable; no extra uart_send; byte order unchanged.
- Drop start mid-REPORT and mid-WRITE → all outputs 0 on the next cycle. Re-raise start → restart at ch0, iter_cnt=0, fresh header.
- Async rst_n low during READ → outputs 0 immediately, without waiting for a clock edge.
